// File: rtl/sd_spi_cmd_responder.sv
// SD-over-SPI command responder: updates the emulated card state for each decoded
// command and shifts the R1/R3/R7 reply MSB-first onto DO after an Ncr gap of 0xFF bytes.
// Optional build macro SPI_RESP_CRC_EN adds io_CrcError; a flagged command only
// returns R1 with the CRC-error bit set.
module sd_spi_cmd_responder #(
    parameter int unsigned NCR_BYTES  = 1,
    parameter logic [31:0] OCR_VALUE  = 32'h00FF8000,
    parameter int unsigned INIT_POLLS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SPI_CLK,
    input  logic        io_SPI_CS,
    input  logic        io_CmdValid,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
`ifdef SPI_RESP_CRC_EN
    input  logic        io_CrcError,
`endif
    output logic        io_SPI_DO,
    output logic        io_Busy,
    output logic        io_InIdle,
    output logic        io_ResponseDone
);

    localparam int unsigned     PollW   = (INIT_POLLS < 2) ? 1 : $clog2(INIT_POLLS + 1);
    localparam logic [PollW-1:0] PollMax = PollW'(INIT_POLLS);
    localparam logic [6:0]      NcrBits = 7'(NCR_BYTES * 8);

    typedef enum logic [1:0] {StIdle, StNcr, StSend, StDone} state_e;

    state_e            state_q, state_d;
    logic              sclk_q;
    logic              do_q, do_d;
    logic              done_q, done_d;
    logic              idle_q, idle_d;
    logic              app_q, app_d;
    logic [PollW-1:0]  poll_q, poll_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [39:0]       shift_q, shift_d;
    logic              long_q, long_d;

    logic              fall;
    logic              accept;
    logic              crc_err;
    logic              dec_long;
    logic              illegal;
    logic [PollW-1:0]  poll_inc;
    logic [7:0]        r1;
    logic [31:0]       ext;
    logic [39:0]       dec_resp;
    logic              unused_arg;

    assign unused_arg = ^io_CommandArgument[31:12];

`ifdef SPI_RESP_CRC_EN
    assign crc_err = io_CrcError;
`else
    assign crc_err = 1'b0;
`endif

    assign fall   = sclk_q & ~io_SPI_CLK;
    assign accept = (state_q == StIdle) && io_CmdValid && !io_SPI_CS;

    // Decode the incoming command into the next card state and the reply buffer.
    always_comb begin
        idle_d   = idle_q;
        app_d    = app_q;
        poll_d   = poll_q;
        illegal  = 1'b0;
        dec_long = 1'b0;
        ext      = 32'h0;
        poll_inc = (poll_q == PollMax) ? poll_q : poll_q + PollW'(1);
        if (accept) begin
            app_d = 1'b0;
            case (io_Command)
                6'd0: begin
                    idle_d = 1'b1;
                    poll_d = '0;
                end
                6'd8: begin
                    dec_long = 1'b1;
                    ext = {20'h0, (io_CommandArgument[11:8] == 4'h1) ? 4'h1 : 4'h0,
                           io_CommandArgument[7:0]};
                end
                6'd55: app_d = 1'b1;
                6'd41: begin
                    if (app_q) begin
                        poll_d = poll_inc;
                        if (poll_inc == PollMax) idle_d = 1'b0;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                6'd58: dec_long = 1'b1;
                6'd59, 6'd16: ;
                default: illegal = 1'b1;
            endcase
            if (io_Command == 6'd58) ext = {~idle_d, OCR_VALUE[30:0]};
        end
        r1 = {5'b0, illegal, 1'b0, idle_d};
        // A CRC failure discards every state effect and reports only the error bit.
        if (crc_err) begin
            idle_d   = idle_q;
            app_d    = app_q;
            poll_d   = poll_q;
            dec_long = 1'b0;
            r1       = {4'b0, 1'b1, 2'b0, idle_q};
        end
        dec_resp = dec_long ? {r1, ext} : {r1, 32'h0};
    end

    // Sequencer: Ncr filler, response shift-out, trailing idle bit, CS abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        long_d  = long_q;
        do_d    = do_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StNcr;
                    cnt_d   = NcrBits;
                    shift_d = dec_resp;
                    long_d  = dec_long;
                    do_d    = 1'b1;
                end
            end
            StNcr: begin
                if (fall) begin
                    do_d = 1'b1;
                    if (cnt_q == 7'd1) begin
                        state_d = StSend;
                        cnt_d   = long_q ? 7'd40 : 7'd8;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end
            end
            StSend: begin
                if (fall) begin
                    do_d    = shift_q[39];
                    shift_d = {shift_q[38:0], 1'b0};
                    cnt_d   = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) state_d = StDone;
                end
            end
            StDone: begin
                if (fall) begin
                    do_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Deselect mid-transaction drops the reply but keeps the card-state update.
        if (state_q != StIdle && io_SPI_CS) begin
            state_d = StIdle;
            do_d    = 1'b1;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sclk_q  <= 1'b0;
            do_q    <= 1'b1;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
            app_q   <= 1'b0;
            poll_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= io_SPI_CLK;
            do_q    <= do_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
            app_q   <= app_d;
            poll_q  <= poll_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            long_q  <= long_d;
        end
    end

    assign io_SPI_DO       = do_q;
    assign io_Busy         = (state_q != StIdle);
    assign io_InIdle       = idle_q;
    assign io_ResponseDone = done_q;

endmodule

// File: tb/tb_sd_spi_cmd_responder.sv
// Directed bench for sd_spi_cmd_responder with hand-computed reply bytes.
module tb_sd_spi_cmd_responder;

    localparam int NcrBits = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [5:0]  command = '0;
    logic [31:0] argument = '0;
`ifdef SPI_RESP_CRC_EN
    logic        crc_error = 1'b0;
`endif
    logic        spi_do, busy, in_idle, resp_done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    sd_spi_cmd_responder #(
        .NCR_BYTES (1),
        .OCR_VALUE (32'h00FF8000),
        .INIT_POLLS(2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_SPI_CLK        (spi_clk),
        .io_SPI_CS         (spi_cs),
        .io_CmdValid       (cmd_valid),
        .io_Command        (command),
        .io_CommandArgument(argument),
`ifdef SPI_RESP_CRC_EN
        .io_CrcError       (crc_error),
`endif
        .io_SPI_DO         (spi_do),
        .io_Busy           (busy),
        .io_InIdle         (in_idle),
        .io_ResponseDone   (resp_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (resp_done) done_cnt <= done_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] cmd, input logic [31:0] arg);
        @(negedge clock);
        cmd_valid = 1'b1;
        command   = cmd;
        argument  = arg;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    // One SPI clock period; returns DO as seen just after the falling edge.
    task automatic spi_bit(output logic b);
        @(negedge clock);
        spi_clk = 1'b1;
        repeat (2) @(negedge clock);
        spi_clk = 1'b0;
        @(negedge clock);
        b = spi_do;
        @(negedge clock);
    endtask

    task automatic get_bits(input int n, output logic [63:0] v);
        logic b;
        v = '0;
        for (int i = 0; i < n; i++) begin
            spi_bit(b);
            v = {v[62:0], b};
        end
    endtask

    task automatic collect(input string tag, input int nbytes, input logic [39:0] exp);
        logic [63:0] v;
        logic        b;
        int          d0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        get_bits(NcrBits, v);
        check({tag, "_ncr"}, v, 64'hFF);
        get_bits(nbytes * 8, v);
        check({tag, "_resp"}, v, 64'(exp));
        d0 = done_cnt;
        spi_bit(b);
        check({tag, "_tail"}, 64'(b), 64'd1);
        check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] cmd, input logic [31:0] arg,
                           input int nbytes, input logic [39:0] exp);
        issue(cmd, arg);
        collect(tag, nbytes, exp);
    endtask

    initial begin
        logic [63:0] v, w;
        int          d0;
        repeat (3) @(negedge clock);
        check("rst_do", 64'(spi_do), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_inidle", 64'(in_idle), 64'd1);
        check("rst_done", 64'(resp_done), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

`ifdef SPI_RESP_CRC_EN
        @(negedge clock);
        crc_error = 1'b1;
        issue(6'd55, 32'h0);
        crc_error = 1'b0;
        collect("crc55", 1, 40'h09);
        run_cmd("crc41", 6'd41, 32'h0, 1, 40'h05);
`endif

        run_cmd("cmd0", 6'd0, 32'h0, 1, 40'h01);
        check("cmd0_inidle", 64'(in_idle), 64'd1);
        run_cmd("cmd8_1aa", 6'd8, 32'h000001AA, 5, 40'h01_00_00_01_AA);
        run_cmd("cmd8_2aa", 6'd8, 32'h000002AA, 5, 40'h01_00_00_00_AA);
        run_cmd("cmd58_idle", 6'd58, 32'h0, 5, 40'h01_00FF8000);
        run_cmd("cmd41_noapp", 6'd41, 32'h0, 1, 40'h05);
        run_cmd("cmd17_idle", 6'd17, 32'h0, 1, 40'h05);
        check("illegal_inidle", 64'(in_idle), 64'd1);
        run_cmd("cmd55_a", 6'd55, 32'h0, 1, 40'h01);
        run_cmd("acmd41_a", 6'd41, 32'h40000000, 1, 40'h01);
        check("poll1_inidle", 64'(in_idle), 64'd1);
        run_cmd("cmd55_b", 6'd55, 32'h0, 1, 40'h01);
        run_cmd("acmd41_b", 6'd41, 32'h40000000, 1, 40'h00);
        check("ready_inidle", 64'(in_idle), 64'd0);
        run_cmd("cmd58_ready", 6'd58, 32'h0, 5, 40'h00_80FF8000);
        run_cmd("cmd16", 6'd16, 32'h200, 1, 40'h00);
        run_cmd("cmd59", 6'd59, 32'h0, 1, 40'h00);
        run_cmd("cmd17_ready", 6'd17, 32'h0, 1, 40'h04);

        // CMD0 pulsed mid-SEND must be ignored entirely.
        issue(6'd58, 32'h0);
        get_bits(NcrBits, v);
        get_bits(4, v);
        issue(6'd0, 32'h0);
        get_bits(36, w);
        check("ign_resp", {24'h0, v[3:0], w[35:0]}, 64'h00_80FF8000);
        d0 = done_cnt;
        get_bits(1, v);
        check("ign_done", 64'(done_cnt - d0), 64'd1);
        check("ign_inidle", 64'(in_idle), 64'd0);

        // CS abort mid-SEND.
        issue(6'd58, 32'h0);
        get_bits(NcrBits + 3, v);
        d0 = done_cnt;
        spi_cs = 1'b1;
        repeat (2) @(negedge clock);
        check("abort_do", 64'(spi_do), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        get_bits(2, v);
        check("abort_nodone", 64'(done_cnt - d0), 64'd0);
        spi_cs = 1'b0;

        // Asynchronous reset mid-response.
        issue(6'd58, 32'h0);
        get_bits(NcrBits + 2, v);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_do", 64'(spi_do), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_inidle", 64'(in_idle), 64'd1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_cmd("post_rst58", 6'd58, 32'h0, 5, 40'h01_00FF8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_cmd_responder.md
Name: sd_spi_cmd_responder

Overview:
Downstream consumer of the SPI command receiver in the SD-card-over-SPI path. It takes each decoded 6-bit command and 32-bit argument, updates the emulated card state (idle, application-command prefix, init progress), builds the R1/R3/R7 response, and shifts it MSB-first onto SPI DO after an Ncr gap of 0xFF bytes. All logic runs on the single system clock; io_SPI_CLK is oversampled.

Parameters:
NCR_BYTES, 1, number of 0xFF filler bytes between command accept and first response byte (1..8)
OCR_VALUE, 32'h00FF8000, OCR reported by CMD58; bit31 is replaced by the power-up-done status
INIT_POLLS, 2, ACMD41 count needed before idle clears (>=1)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
io_SPI_CLK  input  1  SPI clock, sampled on clock
io_SPI_CS  input  1  chip select, active-low
io_CmdValid  input  1  one-cycle pulse: command and argument valid (receiver ReadSuccess)
io_Command  input  6  command index
io_CommandArgument  input  32  command argument
io_SPI_DO  output  1  serial response data, idles high
io_Busy  output  1  high from accept until last response bit is shifted out
io_InIdle  output  1  card idle-state flag (R1 bit0)
io_ResponseDone  output  1  one-cycle pulse after the final response bit

Behaviour:
- Reset values: io_SPI_DO=1, io_Busy=0, io_InIdle=1, io_ResponseDone=0, app_flag=0, poll_cnt=0, state=IDLE.
- Falling edge = registered io_SPI_CLK 1 followed by sampled 0; it is the only shift event.
- States: IDLE -> NCR -> SEND -> DONE -> IDLE.
- IDLE: on io_CmdValid && !io_SPI_CS, latch the command and decode it in the same cycle. Response registers load next cycle. Busy=1, go to NCR.
- io_CmdValid while Busy is ignored: no state change and no response.
- NCR: DO=1 for NCR_BYTES*8 falling edges, then go to SEND.
- SEND: on each falling edge, DO takes the next bit of the response buffer (up to 40 bits), MSB first. After the last bit's edge, go to DONE.
- DONE: on the next falling edge, DO=1. Pulse ResponseDone, Busy=0, go to IDLE.
- R1 byte = {0,0,0,0,0,illegal,0,idle}. idle is the value after the command's update, except for CMD0, which reports 0x01.
- Command decode:
  - CMD0: idle=1, poll_cnt=0, app_flag=0; R1.
  - CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]==1 ? 4'h1 : 4'h0}, arg[7:0].
  - CMD55: app_flag=1; R1.
  - CMD41 with app_flag: poll_cnt increments, saturating at INIT_POLLS; idle clears when poll_cnt reaches INIT_POLLS; R1.
  - CMD58: R3 = R1, then OCR_VALUE with bit31 = !idle.
  - CMD59 and CMD16: R1, no effect.
  - Anything else, including CMD41 without app_flag: R1 with the illegal bit set (0x04 or 0x05).
- app_flag clears on any accepted command other than CMD55.
- io_SPI_CS high in NCR/SEND/DONE aborts to IDLE the next cycle: DO=1, Busy=0, no ResponseDone, card state updates kept.
- An asynchronous reset mid-response returns everything to reset values immediately.

Optional Feature:
SPI_RESP_CRC_EN. Adds input io_CrcError (1 bit, sampled with io_CmdValid). When it is set, the command has no state effect and the reply is R1 with bit3 (CRC error) set, e.g. 0x09 while idle. Without the macro the port is absent and CRC status is ignored.

Test Plan:
- Reset low then high, CMD0 arg 0 -> after 8 DO=1 bits, DO shifts 0x01; ResponseDone pulses; InIdle=1.
- CMD8 arg 0x000001AA -> 8 filler bits then 0x01,0x00,0x00,0x01,0xAA; with arg 0x000002AA the fourth byte is 0x00.
- CMD58 while idle -> 0x01 then 0x00FF8000. After CMD55+ACMD41 twice (INIT_POLLS=2): the second ACMD41 R1 is 0x00, and CMD58 returns 0x00 then 0x80FF8000.
- CMD41 without CMD55 -> 0x05; CMD17 -> 0x05; InIdle unchanged.
- io_CmdValid pulse during SEND -> ignored, current response bits unchanged. Raise CS mid-SEND -> DO=1 next cycle, Busy=0, no ResponseDone.
- With SPI_RESP_CRC_EN: CMD55 with io_CrcError=1 -> R1 0x09; the following ACMD41 returns 0x05.
